// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// uart_tx_arbiter: shares one UART transmitter between NUM_REQ byte streams with
// round-robin arbitration, packet locking and a send/complete handshake sequencer.
//
// state      | meaning
// IDLE       | pick a requester and accept its byte once the TX reports complete
// ISSUE      | pulse tx_send for one cycle, clear the start timer
// WAIT_START | wait for tx_complete to fall, give up after START_TIMEOUT cycles
// WAIT_DONE  | wait for tx_complete to rise, then update lock / rotation point
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 1024
) (
  input  logic                                            clock,
  input  logic                                            reset_n,
  input  logic [NUM_REQ-1:0]                              req_valid,
  input  logic [8*NUM_REQ-1:0]                            req_data,
  input  logic [NUM_REQ-1:0]                              req_last,
  output logic [NUM_REQ-1:0]                              req_ready,
  output logic                                            tx_send,
  output logic [7:0]                                      tx_data,
  input  logic                                            tx_complete,
  output logic                                            busy,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
  output logic                                            timeout_err
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (START_TIMEOUT > 2) ? $clog2(START_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] sel;
  logic          cand;
  logic          locked;
  logic          last_lat;
  logic          accept;
  logic          start_tmo;
  logic [CW-1:0] tmo_cnt;

  // Candidate selection: the lock owner only, else the first valid requester
  // after last_grant (scanned from the far end so the nearest one wins).
  always_comb begin : select_p
    int            idx;
    logic [GW-1:0] idx_g;
    idx   = 0;
    idx_g = '0;
    sel   = grant_id;
    cand  = 1'b0;
    if (locked) begin
      cand = req_valid[grant_id];
    end else begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        idx = int'(last_grant) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        idx_g = GW'(idx);
        if (req_valid[idx_g]) begin
          sel  = idx_g;
          cand = 1'b1;
        end
      end
    end
  end

  assign accept    = reset_n && (state == IDLE) && cand && tx_complete;
  assign start_tmo = (state == WAIT_START) && tx_complete &&
                     (tmo_cnt == CW'(START_TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (accept) state_nxt = ISSUE;
      ISSUE:      state_nxt = WAIT_START;
      WAIT_START: begin
        if (!tx_complete)   state_nxt = WAIT_DONE;
        else if (start_tmo) state_nxt = IDLE;
      end
      WAIT_DONE:  if (tx_complete) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[sel] = 1'b1;
    busy = (state != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_send     <= 1'b0;
      tx_data     <= 8'h00;
      grant_id    <= '0;
      timeout_err <= 1'b0;
      locked      <= 1'b0;
      last_lat    <= 1'b0;
      last_grant  <= GW'(NUM_REQ - 1);
      tmo_cnt     <= '0;
    end else begin
      tx_send     <= (state_nxt == ISSUE);
      timeout_err <= start_tmo;
      if (accept) begin
        tx_data  <= req_data[8*sel +: 8];
        last_lat <= req_last[sel];
        grant_id <= sel;
      end
      case (state)
        ISSUE:      tmo_cnt <= '0;
        WAIT_START: if (tx_complete && !start_tmo) tmo_cnt <= tmo_cnt + 1'b1;
        default:    ;
      endcase
      // A timed-out byte is dropped, so any packet in flight loses its lock.
      if (start_tmo) begin
        locked     <= 1'b0;
        last_grant <= grant_id;
      end
      if ((state == WAIT_DONE) && tx_complete) begin
        if (last_lat) begin
          locked     <= 1'b0;
          last_grant <= grant_id;
        end else begin
          locked <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
// tb_uart_tx_arbiter: table vectors, hand sequences for timeout/reset/back-pressure,
// and randomized packet streams checked against a queue-based round-robin model.
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int TMO = 16;
  localparam int MODE_NORMAL   = 0;
  localparam int MODE_IGNORE   = 1;
  localparam int MODE_HOLD_LOW = 2;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           tx_send;
  logic [7:0]     tx_data;
  logic           tx_complete = 1'b1;
  logic           busy;
  logic [1:0]     grant_id;
  logic           timeout_err;

  int n_checks = 0;
  int n_errors = 0;
  int tx_mode  = MODE_NORMAL;
  int fix_fall = 0;
  int fix_busy = 0;
  int tx_phase = 0;
  int tx_cnt   = 0;

  logic [9:0] sent_q[$];
  logic [8:0] rq[N][$];

  typedef struct packed {
    logic [N-1:0] valid;
    logic [N-1:0] last;
    logic [N-1:0] exp_ready;
    logic [1:0]   exp_grant;
    logic [7:0]   exp_data;
  } vec_t;
  vec_t vecs[12];

  uart_tx_arbiter #(.NUM_REQ(N), .START_TIMEOUT(TMO)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_send(tx_send), .tx_data(tx_data),
    .tx_complete(tx_complete), .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // UART TX model: complete falls some cycles after send, stays low, then rises.
  always @(negedge clock) begin
    case (tx_mode)
      MODE_IGNORE:   begin tx_complete = 1'b1; tx_phase = 0; end
      MODE_HOLD_LOW: begin tx_complete = 1'b0; tx_phase = 0; end
      default: begin
        if (tx_phase == 0) begin
          tx_complete = 1'b1;
          if (tx_send) begin
            tx_phase = 1;
            tx_cnt   = (fix_fall != 0) ? fix_fall : int'($urandom_range(1, 4));
          end
        end else if (tx_phase == 1) begin
          if (tx_cnt <= 1) begin
            tx_complete = 1'b0;
            tx_phase    = 2;
            tx_cnt      = (fix_busy != 0) ? fix_busy : int'($urandom_range(1, 6));
          end else tx_cnt--;
        end else begin
          if (tx_cnt <= 1) begin
            tx_complete = 1'b1;
            tx_phase    = 0;
          end else tx_cnt--;
        end
      end
    endcase
  end

  always @(negedge clock) begin
    #2;
    if (reset_n) begin
      if (tx_send) sent_q.push_back({grant_id, tx_data});
      if (req_ready != '0) begin
        chk("ready one-hot", 32'($onehot(req_ready)), 1);
        chk("ready only to valid", 32'(req_ready & ~req_valid), 0);
      end
    end
  end

  task automatic drive_req(input logic [N-1:0] v, input logic [N-1:0] l, input logic [8*N-1:0] d);
    req_valid = v;
    req_last  = l;
    req_data  = d;
  endtask

  task automatic wait_ready(input string name, output logic [N-1:0] got);
    int c;
    c = 0;
    #1;
    while (req_ready == '0 && c < 200) begin
      @(negedge clock); #1; c++;
    end
    chk($sformatf("%s ready wait", name), 32'(c < 200), 1);
    got = req_ready;
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while (busy && c < 500) begin
      @(negedge clock); #1; c++;
    end
    chk($sformatf("%s idle wait", name), 32'(!busy), 1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    drive_req('0, '0, '0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic send_one(input string name, input logic [N-1:0] v, input logic [N-1:0] l,
                          input logic [8*N-1:0] d, input logic [N-1:0] exp_ready,
                          input logic [1:0] exp_grant, input logic [7:0] exp_data);
    logic [N-1:0] got;
    @(negedge clock);
    drive_req(v, l, d);
    wait_ready(name, got);
    chk($sformatf("%s req_ready", name), 32'(got), 32'(exp_ready));
    @(negedge clock);
    drive_req('0, '0, '0);
    #1;
    chk($sformatf("%s tx_send", name), 32'(tx_send), 1);
    chk($sformatf("%s tx_data", name), 32'(tx_data), 32'(exp_data));
    chk($sformatf("%s grant_id", name), 32'(grant_id), 32'(exp_grant));
    wait_idle(name);
  endtask

  function automatic bit pending();
    bit p;
    p = 1'b0;
    for (int i = 0; i < N; i++) if (rq[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  // Reference: packets leave whole, owners chosen round-robin from the last finished owner.
  task automatic run_stream(input string name);
    logic [8:0] mq[N][$];
    logic [9:0] exp_q[$];
    logic [8:0] b;
    int lg, pick, cyc;
    bit popped;
    for (int i = 0; i < N; i++) mq[i] = rq[i];
    lg = N - 1;
    pick = 0;
    while (pick >= 0) begin
      pick = -1;
      for (int k = 1; k <= N; k++)
        if (pick < 0 && mq[(lg + k) % N].size() > 0) pick = (lg + k) % N;
      if (pick >= 0) begin
        do begin
          b = mq[pick].pop_front();
          exp_q.push_back({2'(pick), b[7:0]});
        end while (!b[8]);
        lg = pick;
      end
    end
    do_reset();
    sent_q.delete();
    cyc = 0;
    popped = 1'b1;
    while ((pending() || busy || popped) && cyc < 5000) begin
      @(negedge clock);
      for (int i = 0; i < N; i++) begin
        req_valid[i]       = (rq[i].size() > 0);
        req_last[i]        = (rq[i].size() > 0) ? rq[i][0][8] : 1'b0;
        req_data[8*i +: 8] = (rq[i].size() > 0) ? rq[i][0][7:0] : 8'h00;
      end
      #1;
      popped = 1'b0;
      for (int i = 0; i < N; i++)
        if (req_ready[i]) begin
          void'(rq[i].pop_front());
          popped = 1'b1;
        end
      cyc++;
    end
    drive_req('0, '0, '0);
    @(negedge clock); #3;
    chk($sformatf("%s finished", name), 32'(cyc < 5000), 1);
    chk($sformatf("%s tx_send count", name), 32'(sent_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < sent_q.size())
        chk($sformatf("%s byte%0d {grant,data}", name, i), 32'(sent_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    logic [N-1:0]   got;
    logic [8*N-1:0] d;
    int c, bad;
    bit saw_low;

    vecs[0]  = {4'b1111, 4'b1111, 4'b1000, 2'd3, 8'h03};
    vecs[1]  = {4'b1011, 4'b1111, 4'b0001, 2'd0, 8'h10};
    vecs[2]  = {4'b0110, 4'b1111, 4'b0010, 2'd1, 8'h21};
    vecs[3]  = {4'b1001, 4'b1111, 4'b1000, 2'd3, 8'h33};
    vecs[4]  = {4'b0010, 4'b1111, 4'b0010, 2'd1, 8'h41};
    vecs[5]  = {4'b0001, 4'b1111, 4'b0001, 2'd0, 8'h50};
    vecs[6]  = {4'b1100, 4'b1111, 4'b0100, 2'd2, 8'h62};
    vecs[7]  = {4'b0110, 4'b1111, 4'b0010, 2'd1, 8'h71};
    vecs[8]  = {4'b1101, 4'b0000, 4'b0100, 2'd2, 8'h82};
    vecs[9]  = {4'b1111, 4'b1111, 4'b0100, 2'd2, 8'h92};
    vecs[10] = {4'b1011, 4'b1111, 4'b1000, 2'd3, 8'hA3};
    vecs[11] = {4'b0101, 4'b1111, 4'b0001, 2'd0, 8'hB0};

    // Reset state, with every requester asking.
    reset_n = 1'b0;
    drive_req('1, '1, 32'hA5A5A5A5);
    repeat (3) @(negedge clock);
    #1;
    chk("reset tx_send", 32'(tx_send), 0);
    chk("reset tx_data", 32'(tx_data), 0);
    chk("reset grant_id", 32'(grant_id), 0);
    chk("reset timeout_err", 32'(timeout_err), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset req_ready", 32'(req_ready), 0);
    @(negedge clock);
    drive_req('0, '0, '0);
    reset_n = 1'b1;
    #1;
    chk("post-reset busy", 32'(busy), 0);
    chk("post-reset req_ready", 32'(req_ready), 0);

    // Single byte from requester 2.
    @(negedge clock);
    drive_req(4'b0100, 4'b0100, 32'hEE5AEEEE);
    wait_ready("single", got);
    chk("single req_ready", 32'(got), 32'b0100);
    @(negedge clock);
    drive_req('0, '0, '0);
    #1;
    chk("single tx_send", 32'(tx_send), 1);
    chk("single tx_data", 32'(tx_data), 32'h5A);
    chk("single grant_id", 32'(grant_id), 2);
    @(negedge clock); #1;
    chk("single tx_send width", 32'(tx_send), 0);
    saw_low = 1'b0;
    c = 0;
    while (busy && c < 100) begin
      if (!tx_complete) saw_low = 1'b1;
      @(negedge clock); #1; c++;
    end
    chk("single busy across TX activity", 32'(saw_low), 1);
    chk("single idle after complete", 32'(!busy && tx_complete), 1);

    for (int e = 0; e < 12; e++) begin
      for (int j = 0; j < N; j++) d[8*j +: 8] = {4'(e), 4'(j)};
      send_one($sformatf("vec%0d", e), vecs[e].valid, vecs[e].last, d,
               vecs[e].exp_ready, vecs[e].exp_grant, vecs[e].exp_data);
    end

    for (int i = 0; i < N; i++)
      for (int k = 0; k < 4; k++) rq[i].push_back({1'b1, 8'(16 * i + k)});
    run_stream("round-robin");

    rq[0].push_back({1'b1, 8'hA0});
    rq[0].push_back({1'b1, 8'hA1});
    rq[1].push_back({1'b0, 8'h11});
    rq[1].push_back({1'b0, 8'h22});
    rq[1].push_back({1'b1, 8'h33});
    rq[3].push_back({1'b1, 8'h3C});
    run_stream("packet-lock");

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) begin
        int npk;
        npk = int'($urandom_range(0, 3));
        for (int p = 0; p < npk; p++) begin
          int len;
          len = int'($urandom_range(1, 3));
          for (int k = 0; k < len; k++) rq[i].push_back({(k == len - 1), 8'($urandom)});
        end
      end
      run_stream($sformatf("random%0d", r));
    end

    // Start timeout: TX never reacts, byte from requester 1 has last=0.
    tx_mode = MODE_IGNORE;
    @(negedge clock);
    drive_req(4'b0010, 4'b0000, 32'h0000C300);
    wait_ready("timeout", got);
    chk("timeout req_ready", 32'(got), 32'b0010);
    @(negedge clock);
    drive_req('0, '0, '0);
    #1;
    chk("timeout tx_send", 32'(tx_send), 1);
    c = 0;
    do begin
      @(negedge clock); #1; c++;
    end while (!timeout_err && c < 40);
    chk("timeout cycles from ISSUE", 32'(c), TMO + 1);
    chk("timeout back in IDLE", 32'(busy), 0);
    @(negedge clock); #1;
    chk("timeout pulse width", 32'(timeout_err), 0);
    tx_mode = MODE_NORMAL;
    send_one("timeout lock released", 4'b0110, 4'b0110, 32'h00343300, 4'b0100, 2'd2, 8'h34);

    // Reset while the TX is busy with a byte.
    fix_fall = 1;
    fix_busy = 30;
    @(negedge clock);
    drive_req(4'b1000, 4'b0000, 32'h77000000);
    wait_ready("rst-mid", got);
    chk("rst-mid req_ready", 32'(got), 32'b1000);
    @(negedge clock);
    drive_req('0, '0, '0);
    #1;
    c = 0;
    while (!(busy && !tx_complete) && c < 50) begin
      @(negedge clock); #1; c++;
    end
    @(negedge clock);
    reset_n = 1'b0;
    drive_req(4'b0100, 4'b0100, 32'h00550000);
    #1;
    chk("rst-mid tx_send", 32'(tx_send), 0);
    chk("rst-mid busy", 32'(busy), 0);
    chk("rst-mid req_ready", 32'(req_ready), 0);
    chk("rst-mid grant_id", 32'(grant_id), 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    drive_req(4'b0111, 4'b0111, 32'h00030201);
    wait_ready("rst-after", got);
    chk("rst-after first grant", 32'(got), 32'b0001);
    @(negedge clock);
    drive_req('0, '0, '0);
    #1;
    chk("rst-after tx_data", 32'(tx_data), 32'h01);
    wait_idle("rst-after");
    fix_fall = 0;
    fix_busy = 0;

    // Back-pressure: TX busy externally while requests are pending.
    do_reset();
    tx_mode = MODE_HOLD_LOW;
    @(negedge clock);
    drive_req(4'b1010, 4'b1010, 32'h44002200);
    #1;
    bad = (req_ready != '0 || tx_send || busy) ? 1 : 0;
    repeat (10) begin
      @(negedge clock); #1;
      if (req_ready != '0 || tx_send || busy) bad++;
    end
    chk("backpressure stall", 32'(bad), 0);
    tx_mode = MODE_NORMAL;
    @(negedge clock); #1;
    chk("backpressure complete rose", 32'(tx_complete), 1);
    chk("backpressure accept same cycle", 32'(req_ready), 32'b0010);
    @(negedge clock);
    drive_req('0, '0, '0);
    #1;
    chk("backpressure tx_data", 32'(tx_data), 32'h22);
    wait_idle("backpressure");

    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
